// File: rtl/mem_a_loader.sv
// Write-side front end for the systolic A-operand memory: collects a DIM x DIM
// row-major element stream and commits each completed row with a one-cycle write strobe.
module mem_a_loader #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  in_valid,
  input  logic signed [BITS_AB-1:0]             in_data,
  output logic                                  in_ready,
  output logic                                  WrEn,
  output logic [$clog2(DIM)-1:0]                Arow,
  output logic signed [DIM-1:0][BITS_AB-1:0]    Ain,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            dbg_state
);

  localparam int RW = $clog2(DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [RW-1:0]                     row_q, col_q;
  logic signed [DIM-1:0][BITS_AB-1:0] row_buf_q;
  logic                              accept;
  logic                              last_col, last_row;

  // Handshake: an element moves on every cycle where in_valid && in_ready.
  // in_ready is a flop that is high exactly while the FSM sits in FILL; the
  // source may drop in_valid at will and in_data is ignored without in_valid.
  assign accept   = in_valid & in_ready;
  assign last_col = (col_q == RW'(DIM - 1));
  assign last_row = (row_q == RW'(DIM - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL: begin
        if (abort)                    state_d = IDLE;
        else if (accept && last_col)  state_d = WRITE;
      end
      WRITE: begin
        if (abort)         state_d = IDLE;
        else if (last_row) state_d = DONE;
        else               state_d = FILL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_buf_q <= '0;
      in_ready  <= 1'b0;
      WrEn      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Status outputs are registered from the next state so they line up with it.
      in_ready <= (state_d == FILL);
      WrEn     <= (state_d == WRITE);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);

      if (state_q == IDLE && start) begin
        row_q <= '0;
        col_q <= '0;
      end

      if (state_q == FILL && accept && !abort) begin
        row_buf_q[col_q] <= in_data;
        col_q            <= col_q + 1'b1;
      end

      if (state_q == WRITE && !abort && !last_row) begin
        row_q <= row_q + 1'b1;
        col_q <= '0;
      end
    end
  end

  // The row buffer is presented directly; it is never cleared between rows.
  assign Arow      = row_q;
  assign Ain       = row_buf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_a_loader.sv
// Self-checking bench for mem_a_loader: table of load scenarios checked against
// a tile model (expected rows are DIM-element chunks of the tile), plus reset corner cases.
module tb_mem_a_loader;

  localparam int B   = 8;
  localparam int DIM = 8;
  localparam int RW  = $clog2(DIM);

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic                          abort;
  logic                          in_valid;
  logic signed [B-1:0]           in_data;
  logic                          in_ready;
  logic                          WrEn;
  logic [RW-1:0]                 Arow;
  logic signed [DIM-1:0][B-1:0]  Ain;
  logic                          busy;
  logic                          done;
  logic [1:0]                    dbg_state;

  mem_a_loader #(.BITS_AB(B), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .WrEn(WrEn), .Arow(Arow), .Ain(Ain), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  logic [DIM*B-1:0] exp_q[$];
  logic [RW-1:0]    exp_row_q[$];
  int               wr_cyc_q[$];
  int               wr_cnt   = 0;
  int               done_cnt = 0;
  int               done_cyc = 0;
  logic [B-1:0]     elem [DIM*DIM];

  always @(negedge clk) begin
    if (WrEn) begin
      wr_cnt++;
      wr_cyc_q.push_back(cyc);
      chk("in_ready_during_wr", in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1'b1, 1'b0);
      end else begin
        chk("ain_row", Ain, exp_q.pop_front());
        chk("arow", Arow, exp_row_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // tile model
  task automatic gen_tile(input int mode);
    for (int i = 0; i < DIM*DIM; i++) begin
      case (mode)
        0: elem[i] = B'(i);
        1: case (i % 4)
             1: elem[i] = 8'hFF;
             2: elem[i] = 8'h80;
             3: elem[i] = 8'h7F;
             default: elem[i] = B'(i);
           endcase
        default: elem[i] = B'($urandom_range(255));
      endcase
    end
  endtask

  task automatic push_rows(input int nrows);
    logic [DIM*B-1:0] r;
    for (int ri = 0; ri < nrows; ri++) begin
      for (int c = 0; c < DIM; c++) r[c*B +: B] = elem[ri*DIM + c];
      exp_q.push_back(r);
      exp_row_q.push_back(RW'(ri));
    end
  endtask

  // driver: feeds elems[0..lim-1] honouring in_ready; returns accepted count and first-accept cycle
  task automatic feed(input int lim, input int gap, input bit glitch,
                      output int idx, output int first_cyc);
    int t;
    idx = 0; t = 0; first_cyc = -1;
    while (idx < lim && t < 5000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = elem[idx];
      start    = glitch && (idx == 30);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (idx == 0) first_cyc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    int gap;
    int abort_n;
    int mode;
    int exp_wr;
    int exp_done;
    bit timing;
    bit glitch;
  } vec_t;

  task automatic run_load(input vec_t v);
    int lim, idx, first_cyc, w0, d0, t;
    gen_tile(v.mode);
    lim = (v.abort_n < 0) ? DIM*DIM : v.abort_n;
    push_rows((v.abort_n < 0) ? DIM : v.abort_n / DIM);
    w0 = wr_cnt; d0 = done_cnt;
    wr_cyc_q.delete();
    pulse_start();
    feed(lim, v.gap, v.glitch, idx, first_cyc);
    chk("accept_count", idx, lim);
    if (v.abort_n >= 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("busy_after_abort", busy, 1'b0);
      repeat (20) @(posedge clk);
      #1;
    end else begin
      t = 0;
      while (done_cnt == d0 && t < 300) begin
        @(negedge clk); #1;
        t++;
      end
      chk("done_seen", (done_cnt != d0), 1'b1);
      if (v.glitch) begin
        start = 1'b1;            // lands in the DONE cycle
        @(posedge clk); #1;
        start = 1'b0;
      end
      repeat (20) @(posedge clk);
      #1;
      chk("busy_after_done", busy, 1'b0);
      if (v.timing) begin
        chk("load_cycles", done_cyc - first_cyc + 1, DIM*DIM + DIM + 1);
        if (wr_cyc_q.size() == DIM) begin
          chk("first_wr_latency", wr_cyc_q[0] - first_cyc, DIM);
          for (int k = 1; k < DIM; k++)
            chk("wr_spacing", wr_cyc_q[k] - wr_cyc_q[k-1], DIM + 1);
          chk("done_after_wr", done_cyc - wr_cyc_q[DIM-1], 1);
        end
      end
    end
    chk("wr_count", wr_cnt - w0, v.exp_wr);
    chk("done_count", done_cnt - d0, v.exp_done);
    chk("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    exp_row_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    int idx, first_cyc, w0;
    vecs[0] = '{gap: 0,  abort_n: -1, mode: 0, exp_wr: 8, exp_done: 1, timing: 1, glitch: 0};
    vecs[1] = '{gap: 50, abort_n: -1, mode: 1, exp_wr: 8, exp_done: 1, timing: 0, glitch: 0};
    vecs[2] = '{gap: 0,  abort_n: -1, mode: 1, exp_wr: 8, exp_done: 1, timing: 0, glitch: 0};
    vecs[3] = '{gap: 0,  abort_n: 21, mode: 0, exp_wr: 2, exp_done: 0, timing: 0, glitch: 0};
    vecs[4] = '{gap: 0,  abort_n: -1, mode: 0, exp_wr: 8, exp_done: 1, timing: 1, glitch: 0};
    vecs[5] = '{gap: 30, abort_n: 40, mode: 2, exp_wr: 5, exp_done: 0, timing: 0, glitch: 0};
    vecs[6] = '{gap: 0,  abort_n: -1, mode: 2, exp_wr: 8, exp_done: 1, timing: 0, glitch: 1};
    vecs[7] = '{gap: 20, abort_n: -1, mode: 2, exp_wr: 8, exp_done: 1, timing: 0, glitch: 0};

    // reset with start held: start must be ignored
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_wren", WrEn, 1'b0);
    chk("rst_arow", Arow, '0);
    chk("rst_ain", Ain, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_after_rst_busy", busy, 1'b0);
    chk("idle_after_rst_ready", in_ready, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // synchronous reset during the WRITE cycle of row 4
    gen_tile(0);
    push_rows(5);
    w0 = wr_cnt;
    pulse_start();
    feed(40, 0, 1'b0, idx, first_cyc);
    chk("rst_seq_accepts", idx, 40);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstw_in_ready", in_ready, 1'b0);
    chk("rstw_wren", WrEn, 1'b0);
    chk("rstw_arow", Arow, '0);
    chk("rstw_ain", Ain, '0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rstw_wr_count", wr_cnt - w0, 5);
    chk("rstw_exp_q_drained", exp_q.size(), 0);
    chk("rstw_busy_later", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
